// File: rtl/freq_gate_ctrl_pkg.sv
// Shared state encodings, default widths and sizing helper for the frequency
// counter gate controller.
package freq_gate_ctrl_pkg;

  localparam int unsigned DEF_GATE_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_RES_W       = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_GATE   = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Measurement control, external counter and result handshake signals of the
// frequency gate controller; master is the controller side.
interface freq_gate_ctrl_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RES_W = 16
);
  logic             start;
  logic             sig_in;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_en;
  logic             cnt_rst;
  logic             busy;
  logic [RES_W-1:0] res_data;
  logic             res_overflow;
  logic             res_valid;
  logic             res_ready;

  modport master (
    input  start, sig_in, cnt_q, res_ready,
    output cnt_en, cnt_rst, busy, res_data, res_overflow, res_valid
  );

  modport slave (
    output start, sig_in, cnt_q, res_ready,
    input  cnt_en, cnt_rst, busy, res_data, res_overflow, res_valid
  );
endinterface

// File: rtl/freq_gate_ctrl_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous input;
// Edge_Pulse is high for one Clk cycle per rising edge.
module sig_edge_sync (
  input  logic Clk,
  input  logic Rst,
  input  logic Sig_In,
  output logic Edge_Pulse
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= Sig_In;
      sync <= meta;
      prev <= sync;
    end
  end

  assign Edge_Pulse = sync & ~prev;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency counter measurement controller: gates edge pulses into an external
// counter for GATE_CYCLES clocks, extends the count with a wrap counter, and
// returns the result on a valid/ready port.
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned RES_W       = DEF_RES_W
) (
  input logic              Clk,
  input logic              Rst,
  freq_gate_ctrl_if.master bus
);
  localparam int unsigned TMR_W = timer_width(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam int unsigned HI_W = RES_W - CNT_W;
  localparam int unsigned HI_S = (HI_W > 0) ? HI_W : 1;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [HI_S-1:0]  hi;
  logic             ovf;
  logic             hi_full;
  logic             edge_pulse;
  logic [RES_W-1:0] full_count;

  sig_edge_sync u_sync (
    .Clk        (Clk),
    .Rst        (Rst),
    .Sig_In     (bus.sig_in),
    .Edge_Pulse (edge_pulse)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_CLEAR;
      ST_CLEAR:  state_nxt = ST_GATE;
      ST_GATE:   if (tmr == TMR_LAST) state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_DONE;
      ST_DONE:   if (bus.res_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Rst)                    tmr <= '0;
    else if (state == ST_CLEAR) tmr <= '0;
    else if (state == ST_GATE)  tmr <= tmr + 1'b1;
  end

  assign bus.cnt_en    = (state == ST_GATE) & edge_pulse;
  assign bus.cnt_rst   = (state == ST_CLEAR);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.res_valid = (state == ST_DONE);

  // With no upper bits every external counter wrap is an overflow.
  assign hi_full = (HI_W == 0) ? 1'b1 : &hi;

  always_ff @(posedge Clk) begin
    if (Rst || state == ST_CLEAR) begin
      hi  <= '0;
      ovf <= 1'b0;
    end else if (bus.cnt_en && (&bus.cnt_q)) begin
      if (hi_full) ovf <= 1'b1;
      else         hi  <= hi + 1'b1;
    end
  end

  if (HI_W > 0) begin : g_hi
    assign full_count = {hi, bus.cnt_q};
  end else begin : g_nohi
    assign full_count = bus.cnt_q;
  end

  // The counter has absorbed the last GATE increment by SETTLE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.res_data     <= '0;
      bus.res_overflow <= 1'b0;
    end else if (state == ST_SETTLE) begin
      bus.res_data     <= ovf ? '1 : full_count;
      bus.res_overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: two instances with behavioural
// 8-bit external counters, edge-window reference model and table-driven runs.
module tb_freq_gate_ctrl;
  localparam int GA  = 100;
  localparam int RWA = 16;
  localparam int GB  = 1200;
  localparam int RWB = 9;

  logic clk = 1'b0;
  logic rst;
  logic sig = 1'b0;
  always #5 clk = ~clk;

  freq_gate_ctrl_if #(.CNT_W(8), .RES_W(RWA)) a_if ();
  freq_gate_ctrl_if #(.CNT_W(8), .RES_W(RWB)) b_if ();

  freq_gate_ctrl #(.GATE_CYCLES(GA), .CNT_W(8), .RES_W(RWA)) dut_a (
    .Clk (clk), .Rst (rst), .bus (a_if.master)
  );
  freq_gate_ctrl #(.GATE_CYCLES(GB), .CNT_W(8), .RES_W(RWB)) dut_b (
    .Clk (clk), .Rst (rst), .bus (b_if.master)
  );

  assign a_if.sig_in = sig;
  assign b_if.sig_in = sig;

  // External 8-bit counters, cleared only by their controller's cnt_rst
  always @(posedge clk) begin
    if (a_if.cnt_rst)     a_if.cnt_q <= 8'd0;
    else if (a_if.cnt_en) a_if.cnt_q <= a_if.cnt_q + 8'd1;
    if (b_if.cnt_rst)     b_if.cnt_q <= 8'd0;
    else if (b_if.cnt_en) b_if.cnt_q <= b_if.cnt_q + 8'd1;
  end

  int errors = 0;
  int checks = 0;
  int t = 0;
  int ph = 1;
  int lo_p = 1;
  int hi_p = 1;
  bit hold = 1'b1;
  logic hold_val = 1'b0;
  int rises[$];

  typedef struct {
    int    w;
    bit    hold;
    logic  hv;
    int    lo;
    int    hi;
    int    exp_d;
    int    exp_o;
    string nm;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp, t);
    end
  endtask

  function automatic int g_valid(input int w); return w ? int'(b_if.res_valid) : int'(a_if.res_valid); endfunction
  function automatic int g_busy(input int w);  return w ? int'(b_if.busy) : int'(a_if.busy); endfunction
  function automatic int g_data(input int w);  return w ? int'(b_if.res_data) : int'(a_if.res_data); endfunction
  function automatic int g_ovf(input int w);   return w ? int'(b_if.res_overflow) : int'(a_if.res_overflow); endfunction
  function automatic int g_en(input int w);    return w ? int'(b_if.cnt_en) : int'(a_if.cnt_en); endfunction
  function automatic int g_crst(input int w);  return w ? int'(b_if.cnt_rst) : int'(a_if.cnt_rst); endfunction

  task automatic set_start(input int w, input logic v);
    if (w != 0) b_if.start = v; else a_if.start = v;
  endtask
  task automatic set_ready(input int w, input logic v);
    if (w != 0) b_if.res_ready = v; else a_if.res_ready = v;
  endtask

  // One clock: outputs are sampled after this returns, sig is driven here
  task automatic tick();
    @(negedge clk);
    t++;
    if (hold) begin
      if (!sig && hold_val) rises.push_back(t);
      sig = hold_val;
    end else if (ph <= 1) begin
      sig = ~sig;
      if (sig) rises.push_back(t);
      ph = int'($urandom_range(hi_p, lo_p));
    end else begin
      ph--;
    end
  endtask

  // Edges driven in the Start tick through G-1 ticks later land in GATE
  function automatic int model_count(input int ts, input int g);
    int n = 0;
    foreach (rises[i]) if (rises[i] >= ts && rises[i] <= ts + g - 1) n++;
    return n;
  endfunction

  task automatic set_mode(input bit h, input logic hv, input int lo, input int hi);
    hold = h; hold_val = hv; lo_p = lo; hi_p = hi; ph = 1;
    repeat (6) tick();
  endtask

  task automatic measure(input int w, input int exp_d, input int exp_o, input string nm);
    int g, rw, ts, n_en, n_rst, cnt, lim, ed, eo;
    g  = w ? GB : GA;
    rw = w ? RWB : RWA;
    tick();
    set_start(w, 1'b1);
    ts = t;
    tick();
    set_start(w, 1'b0);
    n_en = 0; n_rst = 0;
    while (g_valid(w) == 0 && t < ts + g + 20) begin
      n_en  += g_en(w);
      n_rst += g_crst(w);
      tick();
    end
    chk({nm, " latency"}, t - ts, g + 3);
    cnt = model_count(ts, g);
    lim = (1 << rw) - 1;
    ed  = (cnt > lim) ? lim : cnt;
    eo  = (cnt > lim) ? 1 : 0;
    chk({nm, " data"}, g_data(w), ed);
    chk({nm, " ovf"}, g_ovf(w), eo);
    chk({nm, " cnt_en pulses"}, n_en, cnt);
    chk({nm, " cnt_rst cycles"}, n_rst, 1);
    if (exp_d >= 0) begin
      chk({nm, " data table"}, g_data(w), exp_d);
      chk({nm, " ovf table"}, g_ovf(w), exp_o);
    end
    set_ready(w, 1'b1);
    tick();
    set_ready(w, 1'b0);
    chk({nm, " valid after ack"}, g_valid(w), 0);
    chk({nm, " busy after ack"}, g_busy(w), 0);
  endtask

  initial begin
    rst = 1'b1;
    a_if.start = 1'b0; a_if.res_ready = 1'b0;
    b_if.start = 1'b0; b_if.res_ready = 1'b0;
    repeat (3) tick();
    for (int w = 0; w < 2; w++) begin
      chk("reset busy", g_busy(w), 0);
      chk("reset valid", g_valid(w), 0);
      chk("reset data", g_data(w), 0);
      chk("reset ovf", g_ovf(w), 0);
      chk("reset cnt_en", g_en(w), 0);
      chk("reset cnt_rst", g_crst(w), 0);
    end
    rst = 1'b0;
    tick();

    vt.push_back('{0, 1'b0, 1'b0, 5, 5, 10, 0, "A period10"});
    vt.push_back('{0, 1'b0, 1'b0, 2, 2, 25, 0, "A period4"});
    vt.push_back('{0, 1'b1, 1'b0, 1, 1, 0, 0, "A hold0"});
    vt.push_back('{0, 1'b1, 1'b1, 1, 1, 0, 0, "A hold1"});
    vt.push_back('{1, 1'b0, 1'b0, 2, 2, 300, 0, "B period4 wrap"});
    vt.push_back('{1, 1'b0, 1'b0, 1, 1, 511, 1, "B period2 sat"});
    vt.push_back('{0, 1'b0, 1'b0, 1, 7, -1, 0, "A random"});
    vt.push_back('{1, 1'b0, 1'b0, 1, 3, -1, 0, "B random"});
    vt.push_back('{1, 1'b0, 1'b0, 1, 2, -1, 0, "B random fast"});
    for (int i = 0; i < vt.size(); i++) begin
      set_mode(vt[i].hold, vt[i].hv, vt[i].lo, vt[i].hi);
      measure(vt[i].w, vt[i].exp_d, vt[i].exp_o, vt[i].nm);
    end
    for (int k = 0; k < 4; k++) begin
      set_mode(1'b0, 1'b0, 1, int'($urandom_range(6, 2)));
      measure(0, -1, 0, "A random loop");
    end

    // Result held while Ready is low; Start during DONE and at the handshake ignored
    set_mode(1'b0, 1'b0, 5, 5);
    tick();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    for (int i = 0; i < GA + 20 && a_if.res_valid == 1'b0; i++) tick();
    chk("hold valid reached", g_valid(0), 1);
    chk("hold data", g_data(0), 10);
    for (int i = 0; i < 20; i++) begin
      a_if.start = (i == 5);
      tick();
      chk("hold valid stable", g_valid(0), 1);
      chk("hold busy", g_busy(0), 1);
      chk("hold data stable", g_data(0), 10);
    end
    a_if.res_ready = 1'b1;
    a_if.start = 1'b1;
    tick();
    a_if.res_ready = 1'b0;
    a_if.start = 1'b0;
    chk("ack valid low", g_valid(0), 0);
    chk("ack busy low", g_busy(0), 0);
    repeat (3) tick();
    chk("no restart busy", g_busy(0), 0);
    chk("no restart cnt_rst", g_crst(0), 0);

    // Reset mid-GATE
    tick();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    repeat (40) tick();
    chk("mid gate busy", g_busy(0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", g_busy(0), 0);
    chk("rst valid", g_valid(0), 0);
    chk("rst data", g_data(0), 0);
    chk("rst ovf", g_ovf(0), 0);
    chk("rst cnt_en", g_en(0), 0);
    set_mode(1'b0, 1'b0, 5, 5);
    measure(0, 10, 0, "A after reset");
    set_mode(1'b0, 1'b0, 1, 4);
    measure(1, -1, 0, "B after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
